// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: state encoding and default sizing.
package pwm_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int PERIOD_RST_DEF = 99;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : pwm_pkg

// File: rtl/pwm_gen_rise_detect.sv
// Rising-edge detector that turns the divided slow_clk into a one-cycle tick.
// slow_clk is only ever sampled as data in the clkin domain.
// Build option: PWM_GEN_SYNC_EN adds a two-flop synchronizer ahead of the
// edge register (tick latency 3 clkin cycles instead of 1).
module rise_detect (
  input  logic clkin,
  input  logic reset,
  input  logic din,
  output logic tick
);

  logic sampled;
  logic s_d_q;  // previous sampled value of din

`ifdef PWM_GEN_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for a signal that may be asynchronous to clkin.
  always_ff @(posedge clkin) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value, which is what makes this a two-stage chain.
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = din;
`endif

  // Remember last sample so a 0->1 transition can be seen.
  always_ff @(posedge clkin) begin
    if (reset) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= sampled;
    end
  end

  assign tick = sampled & ~s_d_q;

endmodule : rise_detect

// File: rtl/pwm_gen.sv
// PWM generator: counts slow_clk ticks, compares against a shadow duty value,
// and takes new duty/period pairs through a one-deep pending slot that is
// applied only on RUN entry or at a period wrap, so a period is never torn.
// Build option: PWM_GEN_SYNC_EN (see rise_detect) synchronizes slow_clk.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PERIOD_RST = PERIOD_RST_DEF
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] duty_in,
  input  logic [WIDTH-1:0] period_in,
  output logic             ready,
  output logic             pwm_out,
  output logic             period_done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic [WIDTH-1:0] pend_period_q, pend_period_d;
  logic             pend_valid_q, pend_valid_d;
  logic             period_done_q, period_done_d;
  logic             tick;

  rise_detect u_rise_detect (
    .clkin (clkin),
    .reset (reset),
    .din   (slow_clk),
    .tick  (tick)
  );

  // Next-state logic: handshake capture, FSM, counter and shadow update.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    duty_sh_d     = duty_sh_q;
    period_sh_d   = period_sh_q;
    pend_duty_d   = pend_duty_q;
    pend_period_d = pend_period_q;
    pend_valid_d  = pend_valid_q;
    period_done_d = 1'b0;

    // A load is accepted only while the slot is free; a drain below can only
    // happen when the slot is full, so the two never collide.
    if (load && !pend_valid_q) begin
      pend_duty_d   = duty_in;
      pend_period_d = period_in;
      pend_valid_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          cnt_d   = '0;
          if (pend_valid_q) begin
            duty_sh_d    = pend_duty_q;
            period_sh_d  = pend_period_q;
            pend_valid_d = 1'b0;
          end
        end
      end

      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == period_sh_q) begin
            cnt_d         = '0;
            period_done_d = 1'b1;
            if (pend_valid_q) begin
              duty_sh_d    = pend_duty_q;
              period_sh_d  = pend_period_q;
              pend_valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset overriding all other activity.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      duty_sh_q     <= '0;
      period_sh_q   <= WIDTH'(PERIOD_RST);
      pend_duty_q   <= '0;
      pend_period_q <= '0;
      pend_valid_q  <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      duty_sh_q     <= duty_sh_d;
      period_sh_q   <= period_sh_d;
      pend_duty_q   <= pend_duty_d;
      pend_period_q <= pend_period_d;
      pend_valid_q  <= pend_valid_d;
      period_done_q <= period_done_d;
    end
  end

  assign ready       = ~pend_valid_q;
  assign pwm_out     = (state_q == RUN) && (cnt_q < duty_sh_q);
  assign period_done = period_done_q;

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: expected pwm_out/ready per tick are queued
// before each tick is driven and compared once the tick has landed.
module tb_pwm_gen;
  import pwm_pkg::*;

`ifdef PWM_GEN_SYNC_EN
  localparam int TICK_LAT = 3;
`else
  localparam int TICK_LAT = 1;
`endif

  logic       clkin     = 1'b0;
  logic       reset     = 1'b1;
  logic       slow_clk  = 1'b0;
  logic       enable    = 1'b0;
  logic       load      = 1'b0;
  logic [7:0] duty_in   = '0;
  logic [7:0] period_in = '0;
  logic       ready;
  logic       pwm_out;
  logic       period_done;

  int errors  = 0;
  int checks  = 0;
  int pd_seen = 0;
  int pd0     = 0;

  typedef struct {
    string tag;
    logic  pwm;
    logic  rdy;
  } exp_t;

  exp_t sb_q[$];

  always #5 clkin = ~clkin;

  pwm_gen #(.WIDTH(8), .PERIOD_RST(99)) dut (
    .clkin       (clkin),
    .reset       (reset),
    .slow_clk    (slow_clk),
    .enable      (enable),
    .load        (load),
    .duty_in     (duty_in),
    .period_in   (period_in),
    .ready       (ready),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  // Count clkin cycles with period_done high.
  always @(posedge clkin) begin
    if (period_done === 1'b1) pd_seen <= pd_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic pwm, input logic rdy);
    exp_t e;
    e.tag = tag;
    e.pwm = pwm;
    e.rdy = rdy;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, " pwm"}, {31'b0, pwm_out}, {31'b0, e.pwm});
      chk({e.tag, " ready"}, {31'b0, ready}, {31'b0, e.rdy});
    end
  endtask

  // One slow_clk pulse; called and returns at a falling clkin edge.
  task automatic tick_once();
    slow_clk = 1'b1;
    repeat (4) @(negedge clkin);
    slow_clk = 1'b0;
    repeat (4) @(negedge clkin);
  endtask

  // One slow_clk pulse with load held high exactly in the tick cycle.
  task automatic tick_load(input logic [7:0] d, input logic [7:0] p);
    slow_clk = 1'b1;
    repeat (TICK_LAT - 1) @(negedge clkin);
    load      = 1'b1;
    duty_in   = d;
    period_in = p;
    @(negedge clkin);
    load = 1'b0;
    repeat (4 - TICK_LAT) @(negedge clkin);
    slow_clk = 1'b0;
    repeat (4) @(negedge clkin);
  endtask

  task automatic load_pair(input logic [7:0] d, input logic [7:0] p);
    load      = 1'b1;
    duty_in   = d;
    period_in = p;
    @(negedge clkin);
    load = 1'b0;
  endtask

  // Queue n expectations from a known count, then drive and compare each tick.
  task automatic run_ticks(input string tag, input int n, input int start,
                           input int duty, input int period, input logic rdy);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (start + k) % (period + 1);
      push_exp($sformatf("%s[%0d]", tag, k), (c < duty), rdy);
    end
    for (int k = 1; k <= n; k++) begin
      tick_once();
      pop_cmp();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clkin);
    chk("rst_pwm", {31'b0, pwm_out}, 0);
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_pd", {31'b0, period_done}, 0);
    chk("rst_state", {31'b0, dut.state_q}, {31'b0, IDLE});
    chk("rst_cnt", {24'b0, dut.cnt_q}, 0);
    chk("rst_period_sh", {24'b0, dut.period_sh_q}, 99);
    reset = 1'b0;

    // Basic PWM: duty 3, period 9, loaded in IDLE and applied on RUN entry
    load_pair(8'd3, 8'd9);
    chk("idle_load_ready", {31'b0, ready}, 0);
    enable = 1'b1;
    @(negedge clkin);
    chk("entry_state", {31'b0, dut.state_q}, {31'b0, RUN});
    chk("entry_cnt", {24'b0, dut.cnt_q}, 0);
    chk("entry_pwm", {31'b0, pwm_out}, 1);
    chk("entry_ready", {31'b0, ready}, 1);
    pd0 = pd_seen;
    run_ticks("basic", 20, 0, 3, 9, 1'b1);
    chk("basic_pd_count", pd_seen - pd0, 2);

    // Tick latency from slow_clk rise to counter increment
    slow_clk = 1'b1;
    repeat (TICK_LAT - 1) @(negedge clkin);
    chk("lat_before", {24'b0, dut.cnt_q}, 0);
    @(negedge clkin);
    chk("lat_after", {24'b0, dut.cnt_q}, 1);
    slow_clk = 1'b0;
    repeat (4) @(negedge clkin);

    // Enable dropped mid-period
    chk("drop_pre_pwm", {31'b0, pwm_out}, 1);
    enable = 1'b0;
    @(negedge clkin);
    chk("drop_pwm", {31'b0, pwm_out}, 0);
    chk("drop_state", {31'b0, dut.state_q}, {31'b0, IDLE});
    chk("drop_cnt", {24'b0, dut.cnt_q}, 0);

    // Handshake: run (4,9), then load (2,9) mid-period
    load_pair(8'd4, 8'd9);
    enable = 1'b1;
    @(negedge clkin);
    chk("hs_entry_cnt", {24'b0, dut.cnt_q}, 0);
    chk("hs_entry_pwm", {31'b0, pwm_out}, 1);
    chk("hs_entry_ready", {31'b0, ready}, 1);
    run_ticks("hs_a", 3, 0, 4, 9, 1'b1);
    load_pair(8'd2, 8'd9);
    chk("hs_ready_full", {31'b0, ready}, 0);
    load_pair(8'd7, 8'd5);  // slot full: must be ignored
    chk("hs_ready_still", {31'b0, ready}, 0);
    run_ticks("hs_b", 6, 3, 4, 9, 1'b0);
    pd0 = pd_seen;
    // Wrap drains (2,9); load in this cycle is dropped
    push_exp("hs_wrap_drain", 1'b1, 1'b1);
    tick_load(8'd8, 8'd9);
    pop_cmp();
    run_ticks("hs_c", 9, 0, 2, 9, 1'b1);
    // Wrap with empty slot: load (5,9) captured, applied at next wrap
    push_exp("hs_wrap_capture", 1'b1, 1'b0);
    tick_load(8'd5, 8'd9);
    pop_cmp();
    run_ticks("hs_d", 9, 0, 2, 9, 1'b0);
    push_exp("hs_wrap_apply", 1'b1, 1'b1);
    tick_once();
    pop_cmp();
    run_ticks("hs_e", 9, 0, 5, 9, 1'b1);
    chk("hs_pd_count", pd_seen - pd0, 3);

    // Duty limits
    enable = 1'b0;
    @(negedge clkin);
    load_pair(8'd0, 8'd9);
    enable = 1'b1;
    @(negedge clkin);
    chk("lim0_entry_pwm", {31'b0, pwm_out}, 0);
    pd0 = pd_seen;
    run_ticks("lim0", 10, 0, 0, 9, 1'b1);
    chk("lim0_pd_count", pd_seen - pd0, 1);
    enable = 1'b0;
    @(negedge clkin);
    load_pair(8'd12, 8'd9);
    enable = 1'b1;
    @(negedge clkin);
    chk("lim12_entry_pwm", {31'b0, pwm_out}, 1);
    run_ticks("lim12", 10, 0, 12, 9, 1'b1);

    // Reset mid-RUN at cnt = 5, with enable and load also asserted
    run_ticks("pre_rst", 5, 0, 12, 9, 1'b1);
    chk("pre_rst_cnt", {24'b0, dut.cnt_q}, 5);
    reset     = 1'b1;
    load      = 1'b1;
    duty_in   = 8'd3;
    period_in = 8'd3;
    @(negedge clkin);
    chk("mid_rst_pwm", {31'b0, pwm_out}, 0);
    chk("mid_rst_ready", {31'b0, ready}, 1);
    chk("mid_rst_cnt", {24'b0, dut.cnt_q}, 0);
    chk("mid_rst_state", {31'b0, dut.state_q}, {31'b0, IDLE});
    chk("mid_rst_pd", {31'b0, period_done}, 0);
    reset = 1'b0;
    load  = 1'b0;
    @(negedge clkin);
    chk("post_rst_state", {31'b0, dut.state_q}, {31'b0, RUN});
    chk("post_rst_pwm", {31'b0, pwm_out}, 0);
    chk("post_rst_period_sh", {24'b0, dut.period_sh_q}, 99);
    run_ticks("post_rst", 3, 0, 0, 99, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pwm_gen

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the counter, duty and period values.
REQ-002 Parameter: PERIOD_RST, default 99, period value loaded into the shadow register at reset.
REQ-003 Port: clkin  input  1  system clock; all state on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: slow_clk  input  1  divided clock from the upstream clock divider; sampled as data, never used as a clock.
REQ-006 Port: enable  input  1  level; 1 = run, 0 = idle.
REQ-007 Port: load  input  1  one-cycle strobe requesting a new duty/period pair.
REQ-008 Port: duty_in  input  WIDTH  requested duty, in ticks.
REQ-009 Port: period_in  input  WIDTH  requested period minus one, in ticks.
REQ-010 Port: ready  output  1  1 = pending slot free, so a load is accepted.
REQ-011 Port: pwm_out  output  1  PWM waveform.
REQ-012 Port: period_done  output  1  one-cycle pulse at each period wrap.

Function
REQ-013 Tick: the block shall register slow_clk into s_d and assert tick for one clkin cycle when the sampled slow_clk = 1 and s_d = 0.
REQ-014 States: the block shall have exactly two states, IDLE and RUN.
REQ-015 IDLE -> RUN: in IDLE with enable = 1, the block shall enter RUN on the next clkin and set cnt = 0 in the same edge.
- On that entry, if a pending pair is valid, it shall be copied to the shadow registers and pending cleared.
REQ-016 RUN -> IDLE: in RUN with enable = 0, the block shall enter IDLE on the next clkin and set cnt = 0.
- Shadow and pending registers are retained.
REQ-017 Counting: in RUN, each tick with cnt != period_sh shall increment cnt by 1.
REQ-018 Wrap: in RUN, a tick with cnt == period_sh shall, in the same edge:
- set cnt = 0;
- pulse period_done high for exactly one clkin cycle;
- copy pending into the shadow registers if pending is valid, then clear pending.
REQ-019 Period length: one PWM period shall last period_sh + 1 ticks.
REQ-020 Output: pwm_out shall equal (state == RUN) AND (cnt < duty_sh).
- It is decoded from registers only and has zero added latency.
REQ-021 Duty limits: duty_sh = 0 shall hold pwm_out at 0; duty_sh > period_sh shall hold pwm_out at 1 throughout RUN.
REQ-022 Comparisons: all comparisons shall be unsigned at WIDTH bits; cnt shall never exceed period_sh.
REQ-023 Handshake: ready shall equal NOT pending_valid.
- load with ready = 1 captures duty_in and period_in into pending and sets pending_valid.
- load with ready = 0 is ignored; the existing pending pair is unchanged.
REQ-024 Load during wrap: load in the same cycle as a wrap that drains pending shall be ignored, because ready = 0 in that cycle.
- load at a wrap with no pending pair shall be captured and applied at the following wrap.
REQ-025 Load in IDLE: a pair loaded in IDLE shall be applied on RUN entry.

Reset
REQ-026 When reset = 1 at a clkin edge, the block shall set: state = IDLE, cnt = 0, pwm_out = 0, period_done = 0, ready = 1, pending_valid = 0, duty_sh = 0, period_sh = PERIOD_RST, s_d = 0, and all synchronizer flops = 0.
REQ-027 Reset shall override enable, load and tick in the same cycle, including mid-period.

Configuration
REQ-028 With PWM_GEN_SYNC_EN defined, slow_clk shall pass through a two-flop synchronizer before s_d.
- Tick latency from the slow_clk rise is then 3 clkin cycles.
REQ-029 Without PWM_GEN_SYNC_EN, slow_clk shall feed s_d directly.
- Tick latency from the slow_clk rise is then 1 clkin cycle.

Structure
REQ-030 A shared package pwm_pkg shall hold the state encoding (IDLE = 0, RUN = 1) and the default WIDTH and PERIOD_RST constants.
REQ-031 Tick generation, with the optional synchronizer, shall be a sub-module rise_detect (ports clkin, reset, din, tick).

Verification
REQ-032 Reset: assert reset mid-RUN with cnt = 5 -> next cycle pwm_out = 0, ready = 1, cnt = 0, state = IDLE.
REQ-033 Basic PWM: load duty = 3, period = 9, enable = 1 -> pwm_out high for 3 of every 10 ticks; period_done pulses every 10 ticks.
REQ-034 Limits: duty = 0 -> pwm_out stays 0; duty = 12, period = 9 -> pwm_out stays 1 while in RUN.
REQ-035 Handshake:
- load (2, 9) while running (4, 9) -> ready = 0, and new duty 2 takes effect at the next wrap;
- a second load before that wrap is ignored.
REQ-036 Simultaneous events: load asserted in a wrap cycle with pending valid -> load dropped; enable dropped mid-period -> pwm_out = 0 next cycle, re-enable restarts at cnt = 0.
REQ-037 Tick latency: with PWM_GEN_SYNC_EN, cnt increments 3 clkin cycles after the slow_clk rise; without it, 1 cycle after.
